tlut_prod_gen: RTL and testbench

Temporal-LUT product generator: the producer side of the product-matrix interface that the adder tree consumes. It accepts one pair of flattened DIM×DIM operand matrices and sweeps a time ramp t = 0, 1, 2, …. Per-column accumulators hold t·b[c]. When t equals a[r], the block latches the accumulator value into prod[r][c]. The result is the full outer product a[r]·b[c], presented with a valid/ready handshake directly to the adder tree's `prod` input.

---
 rtl/tlut_pkg.sv | 14 +
 rtl/tlut_ramp_acc.sv | 19 +
 rtl/tlut_prod_gen.sv | 97 +++++++++
 tb/tb_tlut_prod_gen.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/tlut_pkg.sv
// tlut_pkg: shared state type, default geometry and helpers for the temporal-LUT product generator.
package tlut_pkg;
    localparam int DEF_DIM        = 3;
    localparam int DEF_DATA_WIDTH = 8;
    localparam int DIM_SQ         = DEF_DIM * DEF_DIM;
    localparam int RAMP_W         = DEF_DATA_WIDTH + 1;
    localparam int MAX_W          = 32;

    typedef enum logic [1:0] {IDLE, RUN, HOLD} state_e;

    function automatic logic [MAX_W-1:0] max_of(input logic [MAX_W-1:0] x, input logic [MAX_W-1:0] y);
        return (x > y) ? x : y;
    endfunction
endpackage

// File: rtl/tlut_ramp_acc.sv
// tlut_ramp_acc: per-column accumulator holding t*b_c, advanced by b_c once per ramp step.
module tlut_ramp_acc #(
    parameter int DATA_WIDTH = 8,
    parameter int ACC_W      = 2 * DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  clear_i,
    input  logic                  en_i,
    input  logic [DATA_WIDTH-1:0] b_c_i,
    output logic [ACC_W-1:0]      acc_o
);
    logic [ACC_W-1:0] acc_q, acc_d;

    always_comb acc_d = clear_i ? '0 : en_i ? acc_q + ACC_W'(b_c_i) : acc_q;

    always_ff @(posedge clk) acc_q <= acc_d;

    assign acc_o = acc_q;
endmodule

// File: rtl/tlut_prod_gen.sv
// tlut_prod_gen: sweeps a time ramp and latches t*b[c] into prod[r][c] when t hits a[r],
// producing the full outer product a[r]*b[c] behind a valid/ready handshake.
module tlut_prod_gen
    import tlut_pkg::*;
#(
    parameter int DIM        = DEF_DIM,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ACC_WIDTH  = 2 * DATA_WIDTH
) (
    input  logic                                            clk,
    input  logic                                            rst,
    input  logic                                            in_valid,
    output logic                                            in_ready,
    input  logic [DIM*DIM-1:0][DATA_WIDTH-1:0]              a,
    input  logic [DIM*DIM-1:0][DATA_WIDTH-1:0]              b,
    output logic                                            out_valid,
    input  logic                                            out_ready,
    output logic [DIM*DIM-1:0][DIM*DIM-1:0][ACC_WIDTH-1:0]  prod
);
    localparam int N  = DIM * DIM;
    localparam int TW = DATA_WIDTH + 1;
    localparam int PW = 2 * DATA_WIDTH;

    if (ACC_WIDTH < 2 * DATA_WIDTH) begin : g_acc_width_check
        $error("ACC_WIDTH must be at least 2*DATA_WIDTH");
    end

    state_e                                 state_q, state_d;
    logic [TW-1:0]                          t_q;
    logic [N-1:0][DATA_WIDTH-1:0]           a_q, b_q;
    logic [DATA_WIDTH-1:0]                  amax_q, amax_d;
    logic [N-1:0][PW-1:0]                   acc;
    logic [N-1:0][N-1:0][ACC_WIDTH-1:0]     prod_q;
    logic [N-1:0]                           hit;
    logic [MAX_W-1:0]                       max_w;
    logic                                   load, run, done;

    assign load = (state_q == IDLE) && in_valid;
    assign run  = (state_q == RUN);
    assign done = run && (t_q == TW'(amax_q));

    always_comb begin
        max_w = '0;
        for (int r = 0; r < N; r++) max_w = max_of(max_w, MAX_W'(a[r]));
        amax_d = DATA_WIDTH'(max_w);
    end

    // One comparator per row; its result gates the capture of every column in that row.
    always_comb begin
        hit = '0;
        for (int r = 0; r < N; r++) hit[r] = (TW'(a_q[r]) == t_q);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = in_valid  ? RUN  : IDLE;
            RUN:     state_d = done      ? HOLD : RUN;
            HOLD:    state_d = out_ready ? IDLE : HOLD;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) state_q <= rst ? IDLE : state_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            t_q    <= '0;
            prod_q <= '0;
        end else if (load) begin
            a_q    <= a;
            b_q    <= b;
            amax_q <= amax_d;
            t_q    <= '0;
            prod_q <= '0;
        end else if (run) begin
            t_q <= t_q + TW'(1);
            for (int r = 0; r < N; r++)
                if (hit[r])
                    for (int c = 0; c < N; c++) prod_q[r][c] <= ACC_WIDTH'(acc[c]);
        end
    end

    for (genvar c = 0; c < N; c++) begin : g_col
        tlut_ramp_acc #(.DATA_WIDTH(DATA_WIDTH), .ACC_W(PW)) u_acc (
            .clk     (clk),
            .clear_i (rst || load),
            .en_i    (run),
            .b_c_i   (b_q[c]),
            .acc_o   (acc[c])
        );
    end

    assign in_ready  = (state_q == IDLE) && !rst;
    assign out_valid = (state_q == HOLD);
    assign prod      = prod_q;
endmodule

// File: tb/tb_tlut_prod_gen.sv
// tb_tlut_prod_gen: table-driven scoreboard bench for the temporal-LUT product generator.
module tb_tlut_prod_gen;
    localparam int DIM = 3;
    localparam int DW  = 8;
    localparam int AW  = 16;
    localparam int N   = DIM * DIM;

    typedef logic [N-1:0][DW-1:0]         vec_t;
    typedef logic [N-1:0][N-1:0][AW-1:0]  prod_t;
    typedef struct { vec_t a; vec_t b; int lat; } vec_rec_t;
    typedef struct { prod_t p; int lat; } exp_t;

    logic  clk = 0, rst = 1, in_valid = 0, out_ready = 0;
    vec_t  a = '0, b = '0;
    logic  in_ready, out_valid;
    prod_t prod;

    int       checks = 0, failures = 0;
    exp_t     sb[$];
    vec_rec_t tbl[5];

    tlut_prod_gen #(.DIM(DIM), .DATA_WIDTH(DW), .ACC_WIDTH(AW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .prod(prod)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0d want=%0d", nm, act, exp);
        end
    endtask

    function automatic prod_t model(input vec_t x, input vec_t y);
        prod_t p;
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) p[r][c] = AW'(x[r]) * AW'(y[c]);
        return p;
    endfunction

    function automatic int count_bad(input prod_t act, input prod_t exp);
        int n = 0;
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) if (act[r][c] !== exp[r][c]) n++;
        return n;
    endfunction

    task automatic scramble();
        for (int i = 0; i < N; i++) begin
            a[i] = DW'($urandom);
            b[i] = DW'($urandom);
        end
    endtask

    task automatic load(input vec_t x, input vec_t y, input int lat);
        exp_t e;
        @(negedge clk);
        chk("load_ready", in_ready, 1);
        in_valid = 1;
        a = x;
        b = y;
        @(posedge clk);
        e.p = model(x, y);
        e.lat = lat;
        sb.push_back(e);
        #1;
        in_valid = 0;
        scramble();
    endtask

    task automatic wait_done();
        exp_t e;
        int n = 0;
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 1, 0);
            return;
        end
        e = sb.pop_front();
        while (!out_valid && n < 400) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("latency", n, e.lat);
        chk("prod_bad_entries", count_bad(prod, e.p), 0);
    endtask

    task automatic release_hold();
        @(negedge clk);
        out_ready = 1;
        @(posedge clk);
        #1;
        chk("release_out_valid", out_valid, 0);
        chk("release_in_ready", in_ready, 1);
        out_ready = 0;
    endtask

    initial begin
        prod_t exp_p;
        logic  held, seen;
        int    m00, m22;
        for (int i = 0; i < N; i++) begin
            tbl[0].a[i] = DW'(i + 1);        tbl[0].b[i] = DW'(i + 2);
            tbl[1].a[i] = '0;                tbl[1].b[i] = 8'd255;
            tbl[2].a[i] = 8'd255;            tbl[2].b[i] = 8'd255;
            tbl[3].a[i] = DW'((i * 5) % 8);  tbl[3].b[i] = DW'(i * 29 + 3);
            tbl[4].a[i] = (i == 5) ? 8'd12 : 8'd0;
            tbl[4].b[i] = DW'(200 - i * 7);
        end
        tbl[0].lat = 10; tbl[1].lat = 1; tbl[2].lat = 256; tbl[3].lat = 8; tbl[4].lat = 13;

        repeat (3) begin
            @(posedge clk);
            #1;
            chk("rst_in_ready", in_ready, 0);
            chk("rst_out_valid", out_valid, 0);
        end
        chk("rst_prod_zero", count_bad(prod, '0), 0);
        @(negedge clk);
        rst = 0;
        #1;
        chk("post_rst_in_ready", in_ready, 1);

        for (int i = 0; i < 5; i++) begin
            load(tbl[i].a, tbl[i].b, tbl[i].lat);
            wait_done();
            if (i == 0) begin
                chk("prod00", prod[0][0], 2);
                chk("prod88", prod[8][8], 90);
                chk("prod42", prod[4][2], 20);
                m00 = 0;
                m22 = 0;
                for (int k = 0; k < DIM; k++) begin
                    m00 += int'(prod[k][k * DIM]);
                    m22 += int'(prod[2 * DIM + k][k * DIM + 2]);
                end
                chk("mult00", m00, 36);
                chk("mult22", m22, 174);
            end
            release_hold();
        end

        load(tbl[0].a, tbl[0].b, tbl[0].lat);
        wait_done();
        exp_p = model(tbl[0].a, tbl[0].b);
        held = 1;
        repeat (5) begin
            @(negedge clk);
            in_valid = ~in_valid;
            scramble();
            @(posedge clk);
            #1;
            held &= out_valid && !in_ready && (count_bad(prod, exp_p) == 0);
        end
        chk("backpressure_hold", held, 1);
        @(negedge clk);
        in_valid = 0;
        release_hold();
        load(tbl[3].a, tbl[3].b, tbl[3].lat);
        wait_done();
        release_hold();

        load(tbl[0].a, tbl[0].b, tbl[0].lat);
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst = 1;
        @(posedge clk);
        #1;
        chk("abort_out_valid", out_valid, 0);
        chk("abort_in_ready_rst", in_ready, 0);
        chk("abort_prod_zero", count_bad(prod, '0), 0);
        @(negedge clk);
        rst = 0;
        void'(sb.pop_back());
        #1;
        chk("abort_idle", in_ready, 1);
        seen = 0;
        repeat (12) begin
            @(posedge clk);
            #1;
            seen |= out_valid;
        end
        chk("abort_no_valid", seen, 0);
        load(tbl[4].a, tbl[4].b, tbl[4].lat);
        wait_done();
        release_hold();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
